// File: rtl/reg_trace_pkg.sv
// Shared constants and entry-layout helpers for the register write tracer.
// Entry layout (MSB..LSB): {addr, data, ts}.
package reg_trace_pkg;

    // Default geometry of the open_risc_v register file and trace entry
    localparam int ADDR_W_DEF = 5;
    localparam int DATA_W_DEF = 32;
    localparam int TS_W_DEF   = 16;

    // Default watch set: x27, x28, x29
    localparam logic [31:0] WATCH_MASK_DEF = 32'h3800_0000;

    // Hard-wired zero register, never traced
    localparam int X0_IDX = 0;

    // Total packed entry width: ENTRY_W = ADDR_W + DATA_W + TS_W
    function automatic int entry_width(input int addr_w, input int data_w, input int ts_w);
        return addr_w + data_w + ts_w;
    endfunction

    // Bit offset of the timestamp field inside an entry
    function automatic int ts_lsb();
        return 0;
    endfunction

    // Bit offset of the data field inside an entry
    function automatic int data_lsb(input int ts_w);
        return ts_w;
    endfunction

    // Bit offset of the register index field inside an entry
    function automatic int addr_lsb(input int data_w, input int ts_w);
        return data_w + ts_w;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO with a registered head and a level counter.
// The head register is loaded on the edge that makes an entry the oldest one,
// so data pushed into an empty FIFO appears on head_data one cycle later.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     srst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic                     head_valid,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] rd_ptr_inc_s;
    logic [LVL_W-1:0] level_r;
    logic [LVL_W-1:0] level_nxt_s;
    logic [WIDTH-1:0] head_r;
    logic [WIDTH-1:0] head_nxt_s;
    logic             valid_r;
    logic             full_s;
    logic             push_ok_s;
    logic             pop_ok_s;

    // Handshake qualification: pop only a present entry, push when room or popping
    always_comb begin
        full_s       = (level_r == LVL_W'(DEPTH));
        pop_ok_s     = pop & valid_r;
        push_ok_s    = push & (~full_s | pop_ok_s);
        rd_ptr_inc_s = rd_ptr_r + PTR_W'(1);
    end

    // Next occupancy and next head entry
    always_comb begin
        level_nxt_s = level_r;
        head_nxt_s  = head_r;
        case ({push_ok_s, pop_ok_s})
            2'b10:   level_nxt_s = level_r + LVL_W'(1);
            2'b01:   level_nxt_s = level_r - LVL_W'(1);
            default: level_nxt_s = level_r;
        endcase
        if (push_ok_s && (level_nxt_s == LVL_W'(1))) begin
            // Pushed word becomes the only entry (empty, or last one leaving)
            head_nxt_s = push_data;
        end else if (pop_ok_s && (level_nxt_s != LVL_W'(0))) begin
            head_nxt_s = mem_r[rd_ptr_inc_s];
        end else if (pop_ok_s) begin
            head_nxt_s = '0;
        end else begin
            head_nxt_s = head_r;
        end
    end

    // Storage array write; contents are meaningless until pointed at
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointers, level counter and registered head
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            level_r  <= '0;
            head_r   <= '0;
            valid_r  <= 1'b0;
        end else if (srst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            level_r  <= '0;
            head_r   <= '0;
            valid_r  <= 1'b0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_inc_s;
            end
            level_r <= level_nxt_s;
            head_r  <= head_nxt_s;
            valid_r <= (level_nxt_s != LVL_W'(0));
        end
    end

    assign head_valid = valid_r;
    assign head_data  = head_r;
    assign level      = level_r;
    assign full       = full_s;
    assign empty      = ~valid_r;

endmodule

// File: rtl/reg_write_trace.sv
// Register-file write tracer: taps the regfile write port, timestamps writes
// to watched registers and streams them out through a FIFO.
// Optional build macro REG_TRACE_CHANGE_ONLY_EN: keep a shadow copy of the
// register file and only trace writes that change a register's value.
module reg_write_trace
    import reg_trace_pkg::*;
#(
    parameter int                        ADDR_W     = ADDR_W_DEF,
    parameter int                        DATA_W     = DATA_W_DEF,
    parameter int                        DEPTH      = 8,
    parameter int                        TS_W       = TS_W_DEF,
    parameter logic [(2**ADDR_W)-1:0]    WATCH_MASK = WATCH_MASK_DEF,
    parameter int                        DROP_W     = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       trace_en,
    input  logic                       wr_en,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    output logic                       trace_valid,
    input  logic                       trace_ready,
    output logic [ADDR_W-1:0]          trace_addr,
    output logic [DATA_W-1:0]          trace_data,
    output logic [TS_W-1:0]            trace_ts,
    output logic [$clog2(DEPTH):0]     fifo_level,
    output logic [DROP_W-1:0]          drop_cnt
);

    localparam int                ENT_W  = entry_width(ADDR_W, DATA_W, TS_W);
    localparam int                TS_LO  = ts_lsb();
    localparam int                DAT_LO = data_lsb(TS_W);
    localparam int                ADR_LO = addr_lsb(DATA_W, TS_W);
    localparam logic [ADDR_W-1:0] X0_A   = ADDR_W'(X0_IDX);

    logic [TS_W-1:0]   ts_r;
    logic [DROP_W-1:0] drop_r;
    logic              watched_s;
    logic              changed_s;
    logic              capture_s;
    logic              drop_s;
    logic              push_s;
    logic              pop_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic [ENT_W-1:0]  entry_s;
    logic [ENT_W-1:0]  head_s;

`ifdef REG_TRACE_CHANGE_ONLY_EN
    localparam int NREG = 2**ADDR_W;
    logic [DATA_W-1:0] shadow_r [NREG];

    // Shadow register file follows every real write, traced or not
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                shadow_r[i] <= '0;
            end
        end else if (wr_en && (wr_addr != X0_A)) begin
            shadow_r[wr_addr] <= wr_data;
        end
    end

    // A write only counts if it changes the register's value
    always_comb begin
        changed_s = (wr_data != shadow_r[wr_addr]);
    end
`else
    // Every qualifying write counts
    always_comb begin
        changed_s = 1'b1;
    end
`endif

    // Capture qualifier, overflow decision and entry packing
    always_comb begin
        entry_s = '0;
        if (wr_addr != X0_A) begin
            watched_s = WATCH_MASK[wr_addr];
        end else begin
            watched_s = 1'b0;
        end
        capture_s = trace_en & wr_en & watched_s & changed_s;
        pop_s     = trace_ready & ~fifo_empty_s;
        drop_s    = capture_s & fifo_full_s & ~pop_s;
        push_s    = capture_s & ~drop_s;
        entry_s[TS_LO  +: TS_W]   = ts_r;
        entry_s[DAT_LO +: DATA_W] = wr_data;
        entry_s[ADR_LO +: ADDR_W] = wr_addr;
    end

    // Free-running timestamp, wraps silently
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ts_r <= '0;
        end else begin
            ts_r <= ts_r + TS_W'(1);
        end
    end

    // Saturating count of events lost to a full FIFO
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drop_r <= '0;
        end else if (drop_s && (drop_r != {DROP_W{1'b1}})) begin
            drop_r <= drop_r + DROP_W'(1);
        end else begin
            drop_r <= drop_r;
        end
    end

    sync_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst),
        .srst       (1'b0),
        .push       (push_s),
        .push_data  (entry_s),
        .pop        (pop_s),
        .head_valid (trace_valid),
        .head_data  (head_s),
        .level      (fifo_level),
        .full       (fifo_full_s),
        .empty      (fifo_empty_s)
    );

    assign trace_ts   = head_s[TS_LO  +: TS_W];
    assign trace_data = head_s[DAT_LO +: DATA_W];
    assign trace_addr = head_s[ADR_LO +: ADDR_W];
    assign drop_cnt   = drop_r;

endmodule
